// File: rtl/meikyuu_room_renderer.sv
// meikyuu_room_renderer
//   VGA room renderer for the meikyuu maze game. Generates VGA timing, holds a
//   writable MAP_W x MAP_H tile map and draws the walls of the current room
//   plus the player sprite. Room tile and sprite position are latched once per
//   frame so the picture never tears.
//
//   Optional feature macro: MEIKYUU_SPRITE_EN (defined = sprite overlay built).
//
// Ports:
//   CLOCK_25            pixel clock
//   reset               asynchronous active-low reset
//   room_x, room_y      current room column/row (3 bits each)
//   player_x, player_y  sprite top-left corner, active-area coordinates
//   map_wr_en           map write strobe; map_wr_x/map_wr_y/map_wr_tile
//   VGA_R/G/B           8-bit colour, VGA_HS/VGA_VS active-low sync
//   VGA_BLANK_N         high in the active area, VGA_SYNC_N constant 0
//   frame_start         one-cycle pulse while the counters read (0,0)
//
// Pipeline: counters -> region compares (stage 1) -> registered outputs
// (stage 2); colour, sync and blank lag the counters by exactly 2 cycles.
module meikyuu_room_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int MAP_W    = 3,
    parameter int MAP_H    = 3,
    parameter int WALL     = 100,
    parameter int SPRITE   = 16
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic [2:0] room_x,
    input  logic [2:0] room_y,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       map_wr_en,
    input  logic [2:0] map_wr_x,
    input  logic [2:0] map_wr_y,
    input  logic [3:0] map_wr_tile,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All region arithmetic is 11 bits wide so sprite edges never wrap.
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] WALL_W  = 11'(WALL);
    localparam logic [10:0] H_RWALL = 11'(H_ACTIVE - WALL);
    localparam logic [10:0] V_BWALL = 11'(V_ACTIVE - WALL);

    // ---------------- stage 0: counters ----------------
    logic [10:0] h, v, h_nx, v_nx;
    logic        running;

    // While not running (first edge after reset) the counters hold at (0,0),
    // so frame_start is raised on that first edge with the counters at (0,0).
    always_comb begin
        h_nx = h;
        v_nx = v;
        if (running) begin
            if (h == H_LAST) begin
                h_nx = 11'd0;
                v_nx = (v == V_LAST) ? 11'd0 : v + 11'd1;
            end else begin
                h_nx = h + 11'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            h           <= 11'd0;
            v           <= 11'd0;
            running     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h           <= h_nx;
            v           <= v_nx;
            running     <= 1'b1;
            frame_start <= (h_nx == 11'd0) && (v_nx == 11'd0);
        end
    end

    // ---------------- tile map ----------------
    logic [3:0] map_q [MAP_H][MAP_W];
    logic [3:0] cell_rd;

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            for (int y = 0; y < MAP_H; y++)
                for (int x = 0; x < MAP_W; x++)
                    map_q[y][x] <= 4'd6;
        end else if (map_wr_en) begin
            // Coordinates that match no cell are simply dropped.
            for (int y = 0; y < MAP_H; y++)
                for (int x = 0; x < MAP_W; x++)
                    if (map_wr_y == 3'(y) && map_wr_x == 3'(x))
                        map_q[y][x] <= map_wr_tile;
        end
    end

    // Out-of-range room reads as solid tile 15.
    always_comb begin
        cell_rd = 4'd15;
        for (int y = 0; y < MAP_H; y++)
            for (int x = 0; x < MAP_W; x++)
                if (room_y == 3'(y) && room_x == 3'(x))
                    cell_rd = map_q[y][x];
    end

    // ---------------- frame latch ----------------
    // The latch edge is the one ending the frame_start cycle. Pixel (0,0) is
    // evaluated on that same edge, so it bypasses to the value being latched;
    // the map write on that edge is not yet visible (read-before-write).
    logic [3:0] tile_q, tile_eff;

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset)           tile_q <= 4'd6;
        else if (frame_start) tile_q <= cell_rd;
    end

    assign tile_eff = frame_start ? cell_rd : tile_q;

    // ---------------- stage 1: region compares ----------------
    logic left, right, top, bottom, active_c, wall_c, spr_hit;

    assign left     = h < WALL_W;
    assign right    = h >= H_RWALL;
    assign top      = v < WALL_W;
    assign bottom   = v >= V_BWALL;
    assign active_c = (h < H_ACT) && (v < V_ACT);

    always_comb begin
        wall_c = 1'b1;
        case (tile_eff)
            4'd0:    wall_c = left | right;
            4'd1:    wall_c = top | bottom;
            4'd2:    wall_c = (top & left) | bottom | right;
            4'd3:    wall_c = (top & right) | bottom | left;
            4'd4:    wall_c = (bottom & right) | top | left;
            4'd5:    wall_c = (bottom & left) | top | right;
            4'd6:    wall_c = (top | bottom) & (left | right);
            default: wall_c = 1'b1;
        endcase
    end

`ifdef MEIKYUU_SPRITE_EN
    localparam logic [10:0] SPR_W = 11'(SPRITE);
    logic [9:0]  px_q, py_q;
    logic [10:0] px_eff, py_eff;

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            px_q <= 10'd0;
            py_q <= 10'd0;
        end else if (frame_start) begin
            px_q <= player_x;
            py_q <= player_y;
        end
    end

    assign px_eff  = frame_start ? {1'b0, player_x} : {1'b0, px_q};
    assign py_eff  = frame_start ? {1'b0, player_y} : {1'b0, py_q};
    // Gating with active_c clips the sprite to the visible area.
    assign spr_hit = active_c && (h >= px_eff) && (h < px_eff + SPR_W)
                              && (v >= py_eff) && (v < py_eff + SPR_W);
`else
    logic unused_player;
    assign unused_player = ^{player_x, player_y};
    assign spr_hit       = 1'b0;
`endif

    logic active_s1, wall_s1, spr_s1, hs_s1, vs_s1;

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            active_s1 <= 1'b0;
            wall_s1   <= 1'b0;
            spr_s1    <= 1'b0;
            hs_s1     <= 1'b1;
            vs_s1     <= 1'b1;
        end else begin
            active_s1 <= active_c;
            wall_s1   <= wall_c;
            spr_s1    <= spr_hit;
            hs_s1     <= !((h >= HS_BEG) && (h < HS_END));
            vs_s1     <= !((v >= VS_BEG) && (v < VS_END));
        end
    end

    // ---------------- stage 2: registered outputs ----------------
    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            {VGA_R, VGA_G, VGA_B} <= 24'd0;
            VGA_HS                <= 1'b1;
            VGA_VS                <= 1'b1;
            VGA_BLANK_N           <= 1'b0;
        end else begin
            VGA_HS      <= hs_s1;
            VGA_VS      <= vs_s1;
            VGA_BLANK_N <= active_s1;
            if (!active_s1)   {VGA_R, VGA_G, VGA_B} <= 24'd0;
            else if (spr_s1)  {VGA_R, VGA_G, VGA_B} <= {8'd153, 8'd51, 8'd153};
            else if (wall_s1) {VGA_R, VGA_G, VGA_B} <= {8'd36, 8'd60, 8'd0};
            else              {VGA_R, VGA_G, VGA_B} <= 24'd0;
        end
    end

    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_meikyuu_room_renderer.sv
// Bench for meikyuu_room_renderer, built with a reduced raster
// (48x32 visible, 56x36 total, WALL 8, SPRITE 4) so each frame is 2016 clocks.
module tb_meikyuu_room_renderer;

    localparam int HA = 48, HF = 2, HSY = 4, HB = 2;
    localparam int VA = 32, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;   // 56
    localparam int VT = VA + VF + VSY + VB;   // 36
    localparam int FRAME = HT * VT;           // 2016

    localparam logic [24:0] C_WALL  = {1'b1, 8'd36, 8'd60, 8'd0};
    localparam logic [24:0] C_FLOOR = {1'b1, 24'd0};
    localparam logic [24:0] C_SPR   = {1'b1, 8'd153, 8'd51, 8'd153};
    localparam logic [24:0] C_BLANK = 25'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] room_x = 3'd0, room_y = 3'd0;
    logic [9:0] player_x = 10'd0, player_y = 10'd0;
    logic       map_wr_en = 1'b0;
    logic [2:0] map_wr_x = 3'd0, map_wr_y = 3'd0;
    logic [3:0] map_wr_tile = 4'd0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;

    int checks = 0;
    int errors = 0;
    int cyc = 1000000;            // cycles since last frame_start sample
    logic [24:0] exp_q[$];

    meikyuu_room_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .MAP_W(3), .MAP_H(3), .WALL(8), .SPRITE(4)
    ) dut (
        .CLOCK_25(clk), .reset(rst_n),
        .room_x(room_x), .room_y(room_y),
        .player_x(player_x), .player_y(player_y),
        .map_wr_en(map_wr_en), .map_wr_x(map_wr_x), .map_wr_y(map_wr_y),
        .map_wr_tile(map_wr_tile),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .frame_start(frame_start)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        if (frame_start) cyc = 0;
        else             cyc++;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin tick(); n++; end while (!frame_start && n < 2 * FRAME);
        if (!frame_start) begin
            checks++; errors++;
            $display("FAIL wait_frame: frame_start=%0b after %0d cycles, required 1", frame_start, n);
        end
    endtask

    // Output pixel (x,y) is visible 2 cycles after the counters reach it.
    task automatic at_pixel(input int x, input int y);
        int target = y * HT + x + 2;
        int n = 0;
        while (cyc != target && n < 2 * FRAME) begin tick(); n++; end
        if (cyc != target) begin
            checks++; errors++;
            $display("FAIL at_pixel(%0d,%0d): cycle %0d, required %0d", x, y, cyc, target);
        end
    endtask

    task automatic write_map(input int x, input int y, input int t);
        map_wr_x = 3'(x); map_wr_y = 3'(y); map_wr_tile = 4'(t);
        map_wr_en = 1'b1;
        tick();
        map_wr_en = 1'b0;
    endtask

    function automatic logic [24:0] pix();
        return {VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [27:0] got;
        rst_n = 1'b0;
        repeat (10) tick();
        got = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start};
        checks++;
        if (got !== {24'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", got, {24'd0, 4'b1100});
        end
        checks++;
        if (VGA_SYNC_N !== 1'b0) begin
            errors++; $display("FAIL sync_n: got %b required 0", VGA_SYNC_N);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (frame_start !== 1'b1) begin
            errors++; $display("FAIL reset_release_fs: got %b required 1", frame_start);
        end
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            errors++; $display("FAIL fs_pulse_width: got %b required 0", frame_start);
        end
    endtask

    task automatic test_timing();
        string nm[7] = '{"hs_first_fall", "hs_second_fall", "hs_low_total",
                         "vs_first_fall", "vs_low_total", "blank_high_total", "frame_period"};
        int    exp_v[7] = '{HA + HF + 2, HA + HF + 2 + HT, HSY * VT,
                            (VA + VF) * HT + 2, VSY * HT, HA * VA, FRAME};
        int    got_v[7];
        int    hs_falls = 0;
        logic  hs_prev;
        logic [24:0] e;
        foreach (exp_v[i]) exp_q.push_back(25'(exp_v[i]));
        foreach (got_v[i]) got_v[i] = 0;
        wait_frame();
        hs_prev = VGA_HS;
        for (int k = 1; k <= FRAME; k++) begin
            tick();
            if (hs_prev && !VGA_HS) begin
                if (hs_falls == 0) got_v[0] = k;
                if (hs_falls == 1) got_v[1] = k;
                hs_falls++;
            end
            hs_prev = VGA_HS;
            if (!VGA_HS) got_v[2]++;
            if (!VGA_VS && got_v[3] == 0) got_v[3] = k;
            if (!VGA_VS) got_v[4]++;
            if (VGA_BLANK_N) got_v[5]++;
            if (frame_start && got_v[6] == 0) got_v[6] = k;
        end
        foreach (got_v[i]) begin
            e = exp_q.pop_front();
            checks++;
            if (25'(got_v[i]) !== e) begin
                errors++;
                $display("FAIL %s: got %0d required %0d", nm[i], got_v[i], e);
            end
        end
    endtask

    task automatic test_tile0();
        int xs[5] = '{4, 24, 44, 50, 4};
        int ys[5] = '{16, 16, 16, 16, 33};
        logic [24:0] es[5] = '{C_WALL, C_FLOOR, C_WALL, C_BLANK, C_BLANK};
        logic [24:0] e, g;
        write_map(1, 0, 0);
        room_x = 3'd1; room_y = 3'd0;
        foreach (es[i]) exp_q.push_back(es[i]);
        wait_frame();
        foreach (xs[i]) begin
            at_pixel(xs[i], ys[i]);
            g = pix(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL tile0 (%0d,%0d): got %h required %h", xs[i], ys[i], g, e);
            end
        end
    endtask

    task automatic test_deferred();
        int xs[4] = '{24, 24, 24, 24};
        int ys[4] = '{4, 28, 4, 28};
        logic [24:0] es[4] = '{C_WALL, C_WALL, C_FLOOR, C_FLOOR};
        logic [24:0] e, g;
        write_map(0, 0, 1);
        room_x = 3'd0; room_y = 3'd0;
        foreach (es[i]) exp_q.push_back(es[i]);
        wait_frame();
        repeat (10) tick();
        room_x = 3'd1;                 // tile-0 room, must wait for next frame
        foreach (xs[i]) begin
            if (i == 2) wait_frame();
            at_pixel(xs[i], ys[i]);
            g = pix(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL deferred[%0d] (%0d,%0d): got %h required %h", i, xs[i], ys[i], g, e);
            end
        end
    endtask

    task automatic test_write_at_latch();
        logic [24:0] e, g;
        room_x = 3'd2; room_y = 3'd2;  // still tile 6 from reset
        exp_q.push_back(C_FLOOR);      // old tile this frame
        exp_q.push_back(C_WALL);       // tile 1 next frame
        wait_frame();
        map_wr_x = 3'd2; map_wr_y = 3'd2; map_wr_tile = 4'd1; map_wr_en = 1'b1;
        tick();
        map_wr_en = 1'b0;
        for (int f = 0; f < 2; f++) begin
            if (f == 1) wait_frame();
            at_pixel(24, 4);
            g = pix(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL write_at_latch frame%0d: got %h required %h", f, g, e);
            end
        end
    endtask

    task automatic test_out_of_range_room();
        int rx[2] = '{5, 0};
        int ry[2] = '{0, 3};
        logic [24:0] e, g;
        foreach (rx[i]) begin
            room_x = 3'(rx[i]); room_y = 3'(ry[i]);
            exp_q.push_back(C_WALL);
            wait_frame();
            at_pixel(24, 16);
            g = pix(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL oor_room(%0d,%0d): got %h required %h", rx[i], ry[i], g, e);
            end
        end
    endtask

    task automatic test_bad_write();
        int rx[3] = '{1, 0, 1};
        int ry[3] = '{1, 1, 0};
        logic [24:0] e, g;
        write_map(4, 4, 7);
        write_map(3, 1, 7);
        write_map(1, 3, 7);
        foreach (rx[i]) begin
            room_x = 3'(rx[i]); room_y = 3'(ry[i]);
            exp_q.push_back(C_FLOOR);
            wait_frame();
            at_pixel(24, 16);
            g = pix(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL bad_write room(%0d,%0d): got %h required %h", rx[i], ry[i], g, e);
            end
        end
    endtask

    task automatic test_sprite();
        int xs[10] = '{20, 19, 24, 23, 20,   0, 46, 48, 1, 47};
        int ys[10] = '{12, 12, 12, 15, 16,  30, 30, 30, 31, 31};
`ifdef MEIKYUU_SPRITE_EN
        logic [24:0] es[10] = '{C_SPR, C_FLOOR, C_FLOOR, C_SPR, C_FLOOR,
                                C_WALL, C_SPR, C_BLANK, C_WALL, C_SPR};
`else
        logic [24:0] es[10] = '{C_FLOOR, C_FLOOR, C_FLOOR, C_FLOOR, C_FLOOR,
                                C_WALL, C_WALL, C_BLANK, C_WALL, C_WALL};
`endif
        logic [24:0] e, g;
        room_x = 3'd1; room_y = 3'd1;  // tile 6
        foreach (es[i]) exp_q.push_back(es[i]);
        foreach (xs[i]) begin
            if (i == 0) begin
                player_x = 10'd20; player_y = 10'd12;
                wait_frame();
            end else if (i == 5) begin
                player_x = 10'd46; player_y = 10'd30;   // hangs past right/bottom
                wait_frame();
            end
            at_pixel(xs[i], ys[i]);
            g = pix(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sprite (%0d,%0d): got %h required %h", xs[i], ys[i], g, e);
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic [24:0] g;
        logic [27:0] r;
        room_x = 3'd1; room_y = 3'd0;  // tile 0
        wait_frame();
        at_pixel(4, 16);
        g = pix();
        checks++;
        if (g !== C_WALL) begin
            errors++; $display("FAIL pre_reset_wall: got %h required %h", g, C_WALL);
        end
        rst_n = 1'b0;
        #1;
        r = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start};
        checks++;
        if (r !== {24'd0, 4'b1100}) begin
            errors++; $display("FAIL async_reset: got %h required %h", r, {24'd0, 4'b1100});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (frame_start !== 1'b1) begin
            errors++; $display("FAIL midframe_release_fs: got %b required 1", frame_start);
        end
        // Map was reloaded with tile 6, so the left band at mid-height is floor.
        at_pixel(4, 16);
        g = pix();
        checks++;
        if (g !== C_FLOOR) begin
            errors++; $display("FAIL map_reset_tile6: got %h required %h", g, C_FLOOR);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_timing();
        test_tile0();
        test_deferred();
        test_write_at_latch();
        test_out_of_range_room();
        test_bad_write();
        test_sprite();
        test_midframe_reset();
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/meikyuu_room_renderer.md
# meikyuu_room_renderer

Parametrised VGA room renderer for the meikyuu maze game: generates VGA timing, holds a writable MAP_W×MAP_H tile map, and draws the current room's walls plus the player sprite. It sits between the player/game logic (room coordinates, sprite position, map writes) and the VGA DAC pins. It replaces the fixed 3×3 hard-wired map and ad-hoc timing. Room, sprite and tile are latched once per frame, so the picture never tears.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (line = 800)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (frame = 525)
- MAP_W, 3, map columns; MAP_H, 3, map rows (both 1..8)
- WALL, 100, wall thickness in pixels
- SPRITE, 16, sprite edge in pixels

Ports:
- CLOCK_25  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- room_x  in  3  current room column
- room_y  in  3  current room row
- player_x  in  10  sprite left edge, active-area coordinates
- player_y  in  10  sprite top edge
- map_wr_en  in  1  map write strobe
- map_wr_x  in  3  write column
- map_wr_y  in  3  write row
- map_wr_tile  in  4  tile code
- VGA_R, VGA_G, VGA_B  out  8 each  colour
- VGA_HS, VGA_VS  out  1  sync, active-low
- VGA_BLANK_N  out  1  high in active area
- VGA_SYNC_N  out  1  constant 0
- frame_start  out  1  one-cycle pulse at h=0, v=0 of the counters

## Operation
- Counters: h runs 0..H_total-1 and wraps to 0. v increments when h wraps and wraps at V_total-1. Active area is h<H_ACTIVE and v<V_ACTIVE.
- Sync: HS is low for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. VS uses the analogous window on v.
- Map: MAP_W×MAP_H×4-bit registers. Reset loads every cell with 6.
  - A write with map_wr_en=1 and in-range coordinates updates the cell on the next edge.
  - Out-of-range writes are ignored.
- Frame latch: at frame_start the block captures room_x, room_y, player_x, player_y and map[room_y][room_x].
  - The latched values are used for the whole frame.
  - Input changes mid-frame take effect at the next frame_start.
  - Out-of-range room coordinates latch tile 15.
- Tile codes (walls are drawn as bands of thickness WALL; "left" means h<WALL, "right" means h≥H_ACTIVE−WALL, "top" means v<WALL, "bottom" means v≥V_ACTIVE−WALL):
  - 0: vertical corridor, left and right bands.
  - 1: horizontal corridor, top and bottom bands.
  - 2: top-left corner block, bottom band, right band.
  - 3: top-right corner block, bottom band, left band.
  - 4: bottom-right corner block, top band, left band.
  - 5: bottom-left corner block, top band, right band.
  - 6: crossroads, four corner blocks only.
  - 7..15: solid, entire active area is wall.
- Colour priority: blanking (0,0,0) > sprite (153,51,153) > wall (36,60,0) > floor (0,0,0).
- Sprite covers player_x ≤ h < player_x+SPRITE and player_y ≤ v < player_y+SPRITE, clipped to the active area. Arithmetic is done in 11 bits, so there is no wrap.

## Timing
- Pipeline: stage 0 is the counters, stage 1 is region compares, stage 2 is the registered colour and sync outputs.
- Every output is registered. Colour, HS, VS and BLANK_N lag the counters by exactly 2 cycles, keeping them mutually aligned.
- frame_start is asserted in the cycle the counters read (0,0). It is not delayed.
- Map write and frame latch in the same cycle: the latch takes the old cell value (read-before-write). The new value is shown from the following frame.
- Reset values:
  - Counters 0.
  - VGA_R/G/B 0, VGA_HS 1, VGA_VS 1, VGA_BLANK_N 0, frame_start 0.
  - Latched room (0,0), latched tile 6, latched sprite position (0,0).
- Reset asserted mid-frame forces the reset values immediately. After release, counting restarts at (0,0) and frame_start pulses on the first edge after release.

## Configuration
- MEIKYUU_SPRITE_EN defined: the sprite overlay is drawn as described above.
- MEIKYUU_SPRITE_EN undefined: player_x and player_y are ignored, no sprite logic is built, and the priority becomes blanking > wall > floor.

## Test plan
- Reset: hold reset low 10 cycles → RGB=0, HS=VS=1, BLANK_N=0. Release → frame_start high after 1 edge.
- Timing: run 2 frames → 800 clocks per line, HS low for 96 clocks starting 656 clocks after line start, VS low for 2 lines, 420000 clocks between frame_start pulses.
- Tile 0 at room (1,0) after write:
  - pixel (50,200) = (36,60,0)
  - pixel (320,200) = (0,0,0)
  - pixel (600,200) = (36,60,0)
- Deferred change: switch room_x mid-frame from a tile-1 room to a tile-0 room → pixel (320,50) stays wall for the rest of the frame and is floor in the next frame.
- Sprite with MEIKYUU_SPRITE_EN, player at (300,200):
  - pixels (300,200) and (315,215) = (153,51,153)
  - pixel (316,200) = floor colour
  - sprite at (630,470) is clipped with no wrap to h=0.
- Edge cases:
  - Map write coincident with frame_start → old tile shown for one frame.
  - room_x=5 with MAP_W=3 → full wall.
  - Write to (4,4) → no cell changes.
